// File: rtl/wb_ctrl_pipe.sv
// Writeback-side control pipeline: carries instr/cmp/pc/valid through STAGES
// registers, decodes per-stage write enable and destination, counts retirements.

module wb_ctrl_dec (
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic       cmp,
  input  logic       valid,
  output logic       we,
  output logic [4:0] a3
);
  logic rtype, wcap, wcond;

  always_comb begin
    rtype = (op == 6'h00);
    wcap  = 1'b0;
    wcond = 1'b1;
    if (rtype) begin
      case (fn)
        6'h21, 6'h23, 6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h09, 6'h10, 6'h12: wcap = 1'b1;
        // movz keeps its rd as destination but only writes when rt==0
        6'h0A: begin wcap = 1'b1; wcond = cmp; end
        default: wcap = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h03: wcap = 1'b1;
        default: wcap = 1'b0;
      endcase
    end
    if (!wcap)            a3 = 5'd0;
    else if (rtype)       a3 = rd;
    else if (op == 6'h03) a3 = 5'd31;
    else                  a3 = rt;
    we = valid & wcap & wcond & (a3 != 5'd0);
  end
endmodule

module wb_ctrl_pipe #(
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_in,
  input  logic                  cmp_in,
  input  logic [31:0]           pc_in,
  input  logic                  valid_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic [31:0]           instr_w,
  output logic [31:0]           pc_w,
  output logic                  valid_w,
  output logic [1:0]            mem2reg,
  output logic                  reg_we,
  output logic [4:0]            reg_a3,
  output logic [STAGES-1:0]     we_all,
  output logic [5*STAGES-1:0]   a3_all,
  output logic [CNT_W-1:0]      retired_cnt
);
  logic [STAGES-1:0][31:0] instr_q, pc_q;
  logic [STAGES-1:0]       cmp_q;
  logic [STAGES:1]         vld_pipe;
  logic [STAGES-1:0][4:0]  a3_s;
  logic [CNT_W-1:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_q  <= '0;
      pc_q     <= '0;
      cmp_q    <= '0;
      vld_pipe <= '0;
    end else if (!stall) begin
      instr_q[0]  <= instr_in;
      pc_q[0]     <= pc_in;
      cmp_q[0]    <= cmp_in;
      vld_pipe[1] <= valid_in;
      for (int i = 1; i < STAGES; i++) begin
        instr_q[i]    <= instr_q[i-1];
        pc_q[i]       <= pc_q[i-1];
        cmp_q[i]      <= cmp_q[i-1];
        vld_pipe[i+1] <= vld_pipe[i];
      end
    end
  end

  // The W instruction at a flush edge is discarded, so it is not counted.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (vld_pipe[STAGES] && !stall && !flush)
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_dec
    wb_ctrl_dec u_dec (
      .op    (instr_q[i][31:26]),
      .fn    (instr_q[i][5:0]),
      .rt    (instr_q[i][20:16]),
      .rd    (instr_q[i][15:11]),
      .cmp   (cmp_q[i]),
      .valid (vld_pipe[i+1]),
      .we    (we_all[i]),
      .a3    (a3_s[i])
    );
  end

  // Result select ignores valid; reg_we alone gates the write.
  always_comb begin
    mem2reg = 2'd0;
    case (instr_w[31:26])
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: mem2reg = 2'd1;
      6'h03:                             mem2reg = 2'd2;
      6'h00: if (instr_w[5:0] == 6'h09)  mem2reg = 2'd2;
      default:                           mem2reg = 2'd0;
    endcase
  end

  assign a3_all      = a3_s;
  assign instr_w     = instr_q[STAGES-1];
  assign pc_w        = pc_q[STAGES-1];
  assign valid_w     = vld_pipe[STAGES];
  assign reg_we      = we_all[STAGES-1];
  assign reg_a3      = a3_s[STAGES-1];
  assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed table-driven bench for wb_ctrl_pipe (STAGES=2, CNT_W=4).
module tb_wb_ctrl_pipe;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset, cmp_in, valid_in, stall, flush;
  logic [31:0] instr_in, pc_in, instr_w, pc_w;
  logic valid_w, reg_we;
  logic [1:0] mem2reg;
  logic [4:0] reg_a3;
  logic [STAGES-1:0] we_all;
  logic [5*STAGES-1:0] a3_all;
  logic [CNT_W-1:0] retired_cnt;

  wb_ctrl_pipe #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .cmp_in(cmp_in), .pc_in(pc_in),
    .valid_in(valid_in), .stall(stall), .flush(flush), .instr_w(instr_w), .pc_w(pc_w),
    .valid_w(valid_w), .mem2reg(mem2reg), .reg_we(reg_we), .reg_a3(reg_a3),
    .we_all(we_all), .a3_all(a3_all), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        cmp;
    logic        valid;
    logic        we;
    logic [4:0]  a3;
    logic [1:0]  m2r;
  } vec_t;

  vec_t vecs[14];
  int n_chk = 0, n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic c, input logic v, input logic [31:0] pc);
    instr_in = ins; cmp_in = c; valid_in = v; pc_in = pc;
  endtask

  task automatic bubble();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic edge_();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'h00221821, 1'b0, 1'b1, 1'b1, 5'd3,  2'd0}; // addu $3
    vecs[1]  = '{32'h8C050004, 1'b0, 1'b1, 1'b1, 5'd5,  2'd1}; // lw $5
    vecs[2]  = '{32'h0C000010, 1'b0, 1'b1, 1'b1, 5'd31, 2'd2}; // jal
    vecs[3]  = '{32'h0022180A, 1'b0, 1'b1, 1'b0, 5'd3,  2'd0}; // movz, cmp=0
    vecs[4]  = '{32'h0022180A, 1'b1, 1'b1, 1'b1, 5'd3,  2'd0}; // movz, cmp=1
    vecs[5]  = '{32'h00220021, 1'b0, 1'b1, 1'b0, 5'd0,  2'd0}; // addu $0
    vecs[6]  = '{32'hAC050004, 1'b0, 1'b1, 1'b0, 5'd0,  2'd0}; // sw
    vecs[7]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, 5'd0,  2'd0}; // nop
    vecs[8]  = '{32'h10220003, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0}; // beq, invalid
    vecs[9]  = '{32'h0020F809, 1'b0, 1'b1, 1'b1, 5'd31, 2'd2}; // jalr $31
    vecs[10] = '{32'h90470000, 1'b0, 1'b1, 1'b1, 5'd7,  2'd1}; // lbu $7
    vecs[11] = '{32'h3C091234, 1'b0, 1'b1, 1'b1, 5'd9,  2'd0}; // lui $9
    vecs[12] = '{32'h00221821, 1'b0, 1'b0, 1'b0, 5'd3,  2'd0}; // addu, invalid
    vecs[13] = '{32'h00220018, 1'b0, 1'b1, 1'b0, 5'd0,  2'd0}; // mult

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    bubble();
    edge_(); edge_();
    reset = 1'b0;
    chk("rst instr_w", instr_w, 0);
    chk("rst pc_w", pc_w, 0);
    chk("rst valid_w", {31'b0, valid_w}, 0);
    chk("rst reg_we", {31'b0, reg_we}, 0);
    chk("rst reg_a3", {27'b0, reg_a3}, 0);
    chk("rst mem2reg", {30'b0, mem2reg}, 0);
    chk("rst we_all", {30'b0, we_all}, 0);
    chk("rst a3_all", {22'b0, a3_all}, 0);
    chk("rst cnt", {28'b0, retired_cnt}, 0);
    exp_cnt = '0;

    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].instr, vecs[k].cmp, vecs[k].valid, 32'h400 + 32'(4 * k));
      edge_();
      chk($sformatf("v%0d we_all", k), {30'b0, we_all}, {31'b0, vecs[k].we});
      chk($sformatf("v%0d a3_s0", k), {27'b0, a3_all[4:0]}, {27'b0, vecs[k].a3});
      chk($sformatf("v%0d a3_s1", k), {27'b0, a3_all[9:5]}, 0);
      if (vecs[k].valid) exp_cnt = exp_cnt + 1'b1;
      bubble();
      edge_();
      chk($sformatf("v%0d reg_we", k), {31'b0, reg_we}, {31'b0, vecs[k].we});
      chk($sformatf("v%0d reg_a3", k), {27'b0, reg_a3}, {27'b0, vecs[k].a3});
      chk($sformatf("v%0d mem2reg", k), {30'b0, mem2reg}, {30'b0, vecs[k].m2r});
      chk($sformatf("v%0d valid_w", k), {31'b0, valid_w}, {31'b0, vecs[k].valid});
      chk($sformatf("v%0d instr_w", k), instr_w, vecs[k].instr);
      chk($sformatf("v%0d pc_w", k), pc_w, 32'h400 + 32'(4 * k));
      // count reflects earlier vectors only; this one commits on the next edge
      chk($sformatf("v%0d cnt", k), {28'b0, retired_cnt},
          {28'b0, exp_cnt - {3'b0, vecs[k].valid}});
    end

    // Stall: A in W, B in stage 0, frozen for three edges.
    drive(32'h00221821, 1'b0, 1'b1, 32'h500); edge_();
    drive(32'h8C050004, 1'b0, 1'b1, 32'h504); edge_();
    chk("pre-stall cnt", {28'b0, retired_cnt}, {28'b0, exp_cnt});
    stall = 1'b1;
    drive(32'h0C000010, 1'b0, 1'b1, 32'h508);
    for (int s = 0; s < 3; s++) begin
      edge_();
      chk($sformatf("stall%0d instr_w", s), instr_w, 32'h00221821);
      chk($sformatf("stall%0d we_all", s), {30'b0, we_all}, 32'h3);
      chk($sformatf("stall%0d cnt", s), {28'b0, retired_cnt}, {28'b0, exp_cnt});
    end
    stall = 1'b0;
    bubble(); edge_();
    exp_cnt = exp_cnt + 1'b1;
    chk("release instr_w", instr_w, 32'h8C050004);
    chk("release reg_a3", {27'b0, reg_a3}, 5);
    chk("release mem2reg", {30'b0, mem2reg}, 1);
    chk("release we_all", {30'b0, we_all}, 32'h2);
    chk("release cnt", {28'b0, retired_cnt}, {28'b0, exp_cnt});

    // Flush together with stall while both stages hold valid work.
    drive(32'h0C000010, 1'b0, 1'b1, 32'h600); edge_();
    exp_cnt = exp_cnt + 1'b1;
    drive(32'h00221821, 1'b0, 1'b1, 32'h604); edge_();
    chk("full mem2reg", {30'b0, mem2reg}, 2);
    chk("full reg_a3", {27'b0, reg_a3}, 31);
    chk("full we_all", {30'b0, we_all}, 32'h3);
    flush = 1'b1; stall = 1'b1;
    drive(32'h00221821, 1'b0, 1'b1, 32'h608); edge_();
    flush = 1'b0; stall = 1'b0;
    chk("flush valid_w", {31'b0, valid_w}, 0);
    chk("flush we_all", {30'b0, we_all}, 0);
    chk("flush a3_all", {22'b0, a3_all}, 0);
    chk("flush instr_w", instr_w, 0);
    chk("flush cnt", {28'b0, retired_cnt}, {28'b0, exp_cnt});
    bubble(); edge_();
    chk("post-flush cnt", {28'b0, retired_cnt}, {28'b0, exp_cnt});

    // Reset mid-stream with valid work in flight.
    drive(32'h00221821, 1'b0, 1'b1, 32'h700); edge_(); edge_(); edge_();
    reset = 1'b1; edge_();
    chk("midrst cnt", {28'b0, retired_cnt}, 0);
    chk("midrst valid_w", {31'b0, valid_w}, 0);
    chk("midrst we_all", {30'b0, we_all}, 0);
    reset = 1'b0;

    // 15 back-to-back commits, then one more wraps the 4-bit counter.
    for (int e = 1; e <= 17; e++) begin
      if (e <= 15) drive(32'h00221821, 1'b0, 1'b1, 32'h800 + 32'(4 * e));
      else         bubble();
      edge_();
      if (e == 16) chk("wrap cnt14", {28'b0, retired_cnt}, 14);
    end
    chk("wrap cnt15", {28'b0, retired_cnt}, 15);
    chk("wrap valid_w", {31'b0, valid_w}, 0);
    drive(32'h00221821, 1'b0, 1'b1, 32'h900); edge_();
    bubble(); edge_();
    chk("wrap hold15", {28'b0, retired_cnt}, 15);
    chk("wrap reg_we", {31'b0, reg_we}, 1);
    edge_();
    chk("wrap to 0", {28'b0, retired_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wb_ctrl_pipe.md
# wb_ctrl_pipe

Parametrised writeback-side control pipeline for the pipelined MIPS CPU. It carries instruction word, compare result, PC and a valid bit through `STAGES` register stages between the memory stage and register-file writeback. At every stage it decodes register-write enable, destination register and result-source select. It adds stall, flush, a per-stage forwarding view and a retired-instruction counter; the single-stage W control unit has none of these.

## Interface
- `STAGES`, 1, number of register stages from M output to W (≥1); stage 0 youngest, stage `STAGES-1` is W.
- `CNT_W`, 32, width of retired-instruction counter.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `instr_in` in 32: instruction leaving M.
- `cmp_in` in 1: compare result from M (movz condition: rt==0).
- `pc_in` in 32: PC of `instr_in`.
- `valid_in` in 1: `instr_in` is a real instruction (0 = bubble).
- `stall` in 1: hold every stage.
- `flush` in 1: invalidate every stage.
- `instr_w` out 32: instruction in W.
- `pc_w` out 32: PC in W.
- `valid_w` out 1: W holds a valid instruction.
- `mem2reg` out 2: W result select; 0 = ALU out, 1 = DM data, 2 = PC+8 link.
- `reg_we` out 1: register-file write enable for W.
- `reg_a3` out 5: destination register for W.
- `we_all` out `STAGES`: effective write enable per stage; bit i = stage i.
- `a3_all` out `5*STAGES`: destination per stage; bits [5i+4:5i] = stage i.
- `retired_cnt` out `CNT_W`: count of instructions committed from W.

## Operation
- Per-stage state: instr[31:0], cmp, pc[31:0], valid.
- Update priority per edge: reset > flush > stall > shift.
  - reset or flush: all stages instr=0, cmp=0, pc=0, valid=0.
  - stall: all stages hold.
  - shift: stage 0 ← inputs; stage i ← stage i-1.
- Decode is combinational per stage. op=instr[31:26], fn=instr[5:0], R-type is op=0.
- Write-capable R-type fn: addu 21, subu 23, add 20, sub 22, sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, jalr 09, mfhi 10, mflo 12, movz 0A. Movz writes only when the stage's cmp=1.
- Write-capable I/J op: addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F, lb 20, lh 21, lw 23, lbu 24, lhu 25, jal 03.
- Destination a3: R-type → rd (instr[15:11]); jal → 31; other write-capable ops → rt (instr[20:16]); non-writing instructions → 0.
- Effective write enable = valid & decoded write & (a3≠0). Writes to $0 are suppressed.
- mem2reg: loads → 1; jal, jalr → 2; else 0. It is driven independently of valid.
- W outputs (`instr_w`, `pc_w`, `valid_w`, `mem2reg`, `reg_we`, `reg_a3`) come from stage `STAGES-1`.
- `retired_cnt` increments by 1 on an edge where valid_w=1, stall=0, flush=0, reset=0. It wraps modulo 2^`CNT_W` and clears on reset only.

## Timing
- Latency: `instr_in` reaches W after `STAGES` unstalled edges. Each stalled edge adds one cycle.
- Outputs are combinational from registers; there is no input-to-output combinational path.
- Reset values: all outputs 0, including `retired_cnt`.
- Flush and stall in the same cycle: flush wins and all stages clear.
- Reset mid-stream: the next edge clears everything; the counter restarts at 0.
- Flush does not clear `retired_cnt`. The instruction in W at a flush edge is not counted.
- `STAGES`=1 behaves as the legacy W control plus stall, flush, valid and the counter.

## Test plan
- Reset, then `STAGES`=2, feed addu $3,$1,$2 (0x00221821, valid) → after 2 edges: reg_we=1, reg_a3=3, mem2reg=0, retired_cnt increments on the following edge. One edge after injection, we_all=2'b01 and a3_all[4:0]=3.
- lw $5,4($0) (0x8C050004), then jal (0x0C000010) → in W: mem2reg=1, reg_a3=5, reg_we=1; next cycle mem2reg=2, reg_a3=31, reg_we=1.
- movz $3,$1,$2 (0x0022180A) with cmp_in=0 → reg_we=0, reg_a3=3. Repeat with cmp_in=1 → reg_we=1.
- addu $0,$1,$2 (0x00220021), sw (0xAC050004) and a nop with valid=1 → reg_we=0 for all three. A beq with valid_in=0 produces no counter increment.
- Stall held 3 cycles with an instruction in stage 0 → all stages and retired_cnt frozen; release → arrival delayed by exactly 3 cycles.
- Flush asserted together with stall while stages are full → next cycle valid_w=0, we_all=0, retired_cnt unchanged. Preset the counter to all-ones via 2^`CNT_W`-1 commits (`CNT_W`=4, i.e. 15 commits), then one more commit → wraps to 0.
